cpu_boot_sequencer: RTL and testbench
=====================================

CPU_BOOT_SEQUENCER -- requirements
Module: cpu_boot_sequencer

Interface
REQ-001 Parameter NUM_INIT, default 2: number of boot words written before CPU release; legal range 1..64.
REQ-002 Parameter DATA_W, default 32: data and address bus width.
REQ-003 Parameter OUT_W, default 8: number of result bits captured from the CPU.
REQ-004 Parameter INIT_BASE, default 32'h02000000: address of boot word 0; word k goes to INIT_BASE + 4*k.
REQ-005 Parameter GAP_CYCLES, default 1: idle cycles after each boot write; legal range 1..15.
REQ-006 Parameter MBOX_ADDR, default 32'h02000000: CPU store address whose data is captured as result bits.
REQ-007 clk  in  1  single system clock; all state updates on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 CPU_start  in  1  level request; only a 0->1 transition starts a sequence.
REQ-010 init_data  in  NUM_INIT*DATA_W  flattened boot words; word k = bits [k*DATA_W +: DATA_W].
REQ-011 Mem_write  in  1  CPU data-store strobe.
REQ-012 WriteData  in  DATA_W  CPU store data.
REQ-013 DataAdr  in  DATA_W  CPU store address.
REQ-014 cpu_reset  out  1  active-high reset driven to the CPU core.
REQ-015 Ext_MemWrite  out  1  external write strobe into data memory.
REQ-016 Ext_WriteData  out  DATA_W  external write data.
REQ-017 Ext_DataAdr  out  DATA_W  external write address.
REQ-018 final_output  out  OUT_W  captured result bits.
REQ-019 busy  out  1  high from the first boot-write cycle until DONE is entered.
REQ-020 done  out  1  high while in DONE.

Function
REQ-021 All outputs are registered; FSM states are IDLE, WRITE, GAP, RUN, DONE.
REQ-022 Start edge: a registered copy of CPU_start is kept; start_edge = CPU_start & ~CPU_start_q.
REQ-023 IDLE or DONE with start_edge -> WRITE on the next cycle; word index k and bit index are cleared, and final_output is cleared.
REQ-024 start_edge in WRITE, GAP or RUN is ignored; CPU_start held high never retriggers.
REQ-025 WRITE, one cycle: Ext_MemWrite=1, Ext_DataAdr=INIT_BASE+4*k (modulo 2^DATA_W), Ext_WriteData=word k, cpu_reset=1; next state is GAP.
REQ-026 GAP lasts exactly GAP_CYCLES cycles with Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, cpu_reset=1.
REQ-027 GAP exit: if k < NUM_INIT-1, increment k and go to WRITE; otherwise go to RUN.
REQ-028 Boot phase duration from the first WRITE to the first RUN cycle is NUM_INIT*(1+GAP_CYCLES) cycles.
REQ-029 RUN: cpu_reset=0 and Ext_* outputs are 0.
REQ-030 RUN capture: when Mem_write=1 and DataAdr==MBOX_ADDR, final_output[bit index] <= WriteData[0] and bit index increments.
REQ-031 A capture writing the bit at index OUT_W-1 moves the FSM to DONE on the next cycle.
REQ-032 Mem_write outside RUN is ignored, including stores to MBOX_ADDR made during WRITE or GAP.
REQ-033 DONE: cpu_reset=1 (CPU halted), done=1, busy=0; final_output holds its value until the next start_edge.
REQ-034 The bit index never exceeds OUT_W-1, and no write beyond final_output is possible.

Reset
REQ-035 reset_n low asynchronously forces: state=IDLE, cpu_reset=1, Ext_MemWrite=0, Ext_DataAdr=0, Ext_WriteData=0, final_output=0, busy=0, done=0, k=0, bit index=0, CPU_start_q=0.
REQ-036 Reset asserted mid-sequence aborts it; after release a new start_edge is required to begin again.
REQ-037 If CPU_start is already high at reset release, that counts as a start_edge on the first clock.

Structure
REQ-038 A shared package holds the FSM state encoding and the default constants INIT_BASE and MBOX_ADDR.
REQ-039 One sub-module, edge_detect_rise, generates start_edge; all other logic is flat.

Verification
REQ-040 Defaults with init_data={32'hA5,32'h5A} and a start pulse -> write 0x5A@0x02000000; one idle cycle; write 0xA5@0x02000004; one idle cycle; cpu_reset falls 4 cycles after the first write.
REQ-041 RUN with 8 stores to 0x02000000 of LSBs 1,0,1,1,0,0,1,0 -> final_output=8'b01001101, done=1, cpu_reset=1.
REQ-042 Stores to 0x02000004 and stores made during GAP -> final_output is unchanged.
REQ-043 CPU_start held high for 20 cycles -> exactly one boot sequence; a second rising edge after DONE -> final_output cleared and the sequence repeats.
REQ-044 NUM_INIT=4, GAP_CYCLES=3 -> addresses 0x02000000/04/08/0C, 16 boot cycles before cpu_reset falls.
REQ-045 reset_n pulsed low during the second WRITE -> all outputs immediately return to reset values, and there is no further activity without a new start edge.

Source files
------------

// File: rtl/cpu_boot_sequencer_pkg.sv
// Shared types and default constants for the CPU boot sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_boot_sequencer_pkg;

  // Sequencer phases: load boot words, idle gaps, let the CPU run, hold result.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } boot_state_t;

  localparam logic [31:0] INIT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] MBOX_ADDR_DEF = 32'h0200_0000;

  // Index width for a counter over n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_boot_sequencer_if.sv
// CPU store port plus external memory write port and CPU reset line.
// Latency: n/a (wiring only).
// Backpressure: none; stores and writes are single-cycle strobes.
interface cpu_boot_sequencer_if #(
  parameter int DATA_W = 32
) ();
  // CPU data-store side, observed by the sequencer
  logic              Mem_write;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] DataAdr;
  // Sequencer-driven side
  logic              cpu_reset;
  logic              Ext_MemWrite;
  logic [DATA_W-1:0] Ext_WriteData;
  logic [DATA_W-1:0] Ext_DataAdr;

  modport master (
    input  Mem_write, WriteData, DataAdr,
    output cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );

  modport slave (
    output Mem_write, WriteData, DataAdr,
    input  cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );
endinterface

// File: rtl/cpu_boot_sequencer_edge_detect_rise.sv
// Rising-edge detector: one-cycle pulse when sig_i goes 0->1.
// Latency: combinational pulse in the cycle sig_i first reads high.
// Backpressure: none.
module edge_detect_rise (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  // Remember last cycle's level; cleared by reset so a level already high
  // at release is seen as an edge on the first clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig_i;
  end

  assign edge_o = sig_i & ~sig_q;

endmodule

// File: rtl/cpu_boot_sequencer.sv
// Writes boot words into data memory, releases the CPU, captures result bits from mailbox stores.
// Latency: first boot write one cycle after the start edge; all outputs registered.
// Backpressure: none; CPU stores are sampled every RUN cycle, start edges outside IDLE/DONE are dropped.
module cpu_boot_sequencer
  import cpu_boot_sequencer_pkg::*;
#(
  parameter int                 NUM_INIT   = 2,
  parameter int                 DATA_W     = 32,
  parameter int                 OUT_W      = 8,
  parameter logic [DATA_W-1:0]  INIT_BASE  = DATA_W'(INIT_BASE_DEF),
  parameter int                 GAP_CYCLES = 1,
  parameter logic [DATA_W-1:0]  MBOX_ADDR  = DATA_W'(MBOX_ADDR_DEF)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       CPU_start,
  input  logic [NUM_INIT*DATA_W-1:0] init_data,
  output logic [OUT_W-1:0]           final_output,
  output logic                       busy,
  output logic                       done,
  cpu_boot_sequencer_if.master       bus
);

  localparam int KW = idx_w(NUM_INIT);
  localparam int BW = idx_w(OUT_W);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_INIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(OUT_W - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

  boot_state_t       state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [3:0]        gap_q, gap_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_edge;
  logic              mbox_hit;
  logic [DATA_W-1:0] words [NUM_INIT];
  logic              unused_wdata;

  edge_detect_rise u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_i   (CPU_start),
    .edge_o  (start_edge)
  );

  for (genvar i = 0; i < NUM_INIT; i++) begin : g_words
    assign words[i] = init_data[i*DATA_W +: DATA_W];
  end

  // Only the store LSB carries result information.
  assign unused_wdata = ^bus.WriteData[DATA_W-1:1];
  assign mbox_hit     = bus.Mem_write && (bus.DataAdr == MBOX_ADDR);

  // Next-state and next-output logic; outputs derive from the next state so
  // every registered output lines up with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_d  = ST_WRITE;
          k_d      = '0;
          bit_d    = '0;
          result_d = '0;
        end
      end
      ST_WRITE: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (k_q != K_LAST) begin
            k_d     = k_q + 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (mbox_hit) begin
          result_d[bit_q] = bus.WriteData[0];
          // Bit index saturates at the top bit; the last capture ends the run.
          if (bit_q == BIT_LAST) state_d = ST_DONE;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_d        = (state_d == ST_WRITE);
    adr_d       = wr_d ? (INIT_BASE + (DATA_W'(k_d) << 2)) : '0;
    dat_d       = wr_d ? words[k_d] : '0;
    cpu_reset_d = (state_d != ST_RUN);
    busy_d      = (state_d == ST_WRITE) || (state_d == ST_GAP) || (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      result_q    <= '0;
      cpu_reset_q <= 1'b1;
      wr_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      result_q    <= result_d;
      cpu_reset_q <= cpu_reset_d;
      wr_q        <= wr_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cpu_reset     = cpu_reset_q;
  assign bus.Ext_MemWrite  = wr_q;
  assign bus.Ext_DataAdr   = adr_q;
  assign bus.Ext_WriteData = dat_q;
  assign final_output      = result_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
module tb_cpu_boot_sequencer;

  localparam int          NI1  = 2;
  localparam int          GAP1 = 1;
  localparam int          NI2  = 4;
  localparam int          GAP2 = 3;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] MBOX = 32'h0200_0000;

  logic         clk;
  logic         reset_n;
  logic         CPU_start, CPU_start2;
  logic [63:0]  init_data;
  logic [127:0] init_data2;
  logic [7:0]   final_output, final_output2;
  logic         busy, busy2, done, done2;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_boot_sequencer_if #(.DATA_W(32)) bus1 ();
  cpu_boot_sequencer_if #(.DATA_W(32)) bus2 ();

  cpu_boot_sequencer dut (
    .clk(clk), .reset_n(reset_n), .CPU_start(CPU_start), .init_data(init_data),
    .final_output(final_output), .busy(busy), .done(done), .bus(bus1)
  );

  cpu_boot_sequencer #(.NUM_INIT(NI2), .GAP_CYCLES(GAP2)) dut2 (
    .clk(clk), .reset_n(reset_n), .CPU_start(CPU_start2), .init_data(init_data2),
    .final_output(final_output2), .busy(busy2), .done(done2), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and
  // registered outputs are sampled at this point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (bus1.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset got %b exp 1", bus1.cpu_reset); end
    n_checks++; if (bus1.Ext_MemWrite !== 1'b0) begin n_fail++; $display("FAIL rst_memwrite got %b exp 0", bus1.Ext_MemWrite); end
    n_checks++; if (bus1.Ext_DataAdr !== 32'h0) begin n_fail++; $display("FAIL rst_adr got %h exp 0", bus1.Ext_DataAdr); end
    n_checks++; if (bus1.Ext_WriteData !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", bus1.Ext_WriteData); end
    n_checks++; if (final_output !== 8'h0) begin n_fail++; $display("FAIL rst_final got %h exp 0", final_output); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
    n_checks++; if (bus2.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset2 got %b exp 1", bus2.cpu_reset); end
    reset_n = 1'b1;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  // Boot phase on the default instance. Offset o counts cycles from the first
  // write; writes fall on multiples of (1+GAP), word o/(1+GAP). With noise,
  // mailbox stores are issued throughout and must not touch the result.
  task automatic test_boot(input logic [63:0] words, input bit noise);
    int          period, total, widx;
    logic        exp_wr;
    logic [31:0] exp_adr, exp_dat;
    period = 1 + GAP1;
    total  = NI1 * period;
    init_data = words;
    CPU_start = 1'b1;
    tick();
    CPU_start = 1'b0;
    for (int off = 0; off <= total; off++) begin
      exp_wr  = (off < total) && ((off % period) == 0);
      widx    = off / period;
      exp_adr = 32'h0;
      exp_dat = 32'h0;
      if (exp_wr) begin
        exp_adr = BASE + 32'(4 * widx);
        exp_dat = words[widx*32 +: 32];
      end
      n_checks++; if (bus1.Ext_MemWrite !== exp_wr) begin n_fail++; $display("FAIL boot_wr off=%0d got %b exp %b", off, bus1.Ext_MemWrite, exp_wr); end
      n_checks++; if (bus1.Ext_DataAdr !== exp_adr) begin n_fail++; $display("FAIL boot_adr off=%0d got %h exp %h", off, bus1.Ext_DataAdr, exp_adr); end
      n_checks++; if (bus1.Ext_WriteData !== exp_dat) begin n_fail++; $display("FAIL boot_dat off=%0d got %h exp %h", off, bus1.Ext_WriteData, exp_dat); end
      n_checks++; if (bus1.cpu_reset !== (off < total)) begin n_fail++; $display("FAIL boot_cpu_reset off=%0d got %b exp %b", off, bus1.cpu_reset, (off < total)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL boot_busy off=%0d got %b exp 1", off, busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL boot_done off=%0d got %b exp 0", off, done); end
      n_checks++; if (final_output !== 8'h0) begin n_fail++; $display("FAIL boot_final off=%0d got %h exp 0", off, final_output); end
      if (off < total) begin
        bus1.Mem_write = noise;
        bus1.DataAdr   = MBOX;
        bus1.WriteData = $urandom | 32'h1;
        tick();
      end
    end
    bus1.Mem_write = 1'b0;
  endtask

  // RUN phase: bit i of the result is the LSB of the i-th mailbox store.
  task automatic test_capture(input logic [7:0] bits, input bit noise);
    logic [7:0] exp;
    int         n;
    exp = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (noise) begin
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) begin
          bus1.Mem_write = 1'($urandom_range(0, 1));
          bus1.DataAdr   = MBOX + 32'(4 * $urandom_range(1, 3));
          bus1.WriteData = $urandom;
          tick();
        end
      end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cap_done_early i=%0d got %b exp 0", i, done); end
      bus1.Mem_write = 1'b1;
      bus1.DataAdr   = MBOX;
      bus1.WriteData = {$urandom_range(0, 32'h7FFF_FFFF), bits[i]};
      tick();
      bus1.Mem_write = 1'b0;
      exp[i] = bits[i];
      n_checks++; if (final_output !== exp) begin n_fail++; $display("FAIL cap_partial i=%0d got %b exp %b", i, final_output, exp); end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cap_done got %b exp 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cap_busy got %b exp 0", busy); end
    n_checks++; if (bus1.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL cap_cpu_reset got %b exp 1", bus1.cpu_reset); end
    for (int j = 0; j < 3; j++) begin
      bus1.Mem_write = 1'b1;
      bus1.DataAdr   = MBOX;
      bus1.WriteData = {31'h0, ~exp[j]};
      tick();
    end
    bus1.Mem_write = 1'b0;
    n_checks++; if (final_output !== exp) begin n_fail++; $display("FAIL done_hold got %b exp %b", final_output, exp); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_hold_done got %b exp 1", done); end
  endtask

  // A start level held high yields one boot sequence, ending in RUN.
  task automatic test_hold_start();
    int writes, first_run;
    writes    = 0;
    first_run = -1;
    CPU_start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      writes += int'(bus1.Ext_MemWrite);
      if (first_run < 0 && bus1.cpu_reset === 1'b0) first_run = c;
    end
    n_checks++; if (writes !== NI1) begin n_fail++; $display("FAIL hold_writes got %0d exp %0d", writes, NI1); end
    n_checks++; if (first_run !== NI1 * (1 + GAP1)) begin n_fail++; $display("FAIL hold_release got %0d exp %0d", first_run, NI1 * (1 + GAP1)); end
    n_checks++; if (bus1.cpu_reset !== 1'b0) begin n_fail++; $display("FAIL hold_run got %b exp 0", bus1.cpu_reset); end
    n_checks++; if (final_output !== 8'h0) begin n_fail++; $display("FAIL hold_cleared got %h exp 0", final_output); end
    CPU_start = 1'b0;
  endtask

  task automatic test_reset_midseq();
    init_data = {$urandom, $urandom};
    CPU_start = 1'b1;
    tick();
    CPU_start = 1'b0;
    tick();
    tick();
    n_checks++; if (bus1.Ext_MemWrite !== 1'b1) begin n_fail++; $display("FAIL mid_second_write got %b exp 1", bus1.Ext_MemWrite); end
    n_checks++; if (bus1.Ext_DataAdr !== BASE + 32'h4) begin n_fail++; $display("FAIL mid_second_adr got %h exp %h", bus1.Ext_DataAdr, BASE + 32'h4); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus1.Ext_MemWrite !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr got %b exp 0", bus1.Ext_MemWrite); end
    n_checks++; if (bus1.Ext_DataAdr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_adr got %h exp 0", bus1.Ext_DataAdr); end
    n_checks++; if (bus1.Ext_WriteData !== 32'h0) begin n_fail++; $display("FAIL mid_rst_dat got %h exp 0", bus1.Ext_WriteData); end
    n_checks++; if (bus1.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cpu_reset got %b exp 1", bus1.cpu_reset); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %b exp 0", done); end
    n_checks++; if (final_output !== 8'h0) begin n_fail++; $display("FAIL mid_rst_final got %h exp 0", final_output); end
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (bus1.Ext_MemWrite !== 1'b0 || busy !== 1'b0 || bus1.cpu_reset !== 1'b1) begin
        n_fail++; $display("FAIL mid_quiet c=%0d got wr=%b busy=%b cpu_reset=%b exp 0/0/1", c, bus1.Ext_MemWrite, busy, bus1.cpu_reset);
      end
    end
  endtask

  task automatic test_reset_start_high();
    reset_n   = 1'b0;
    CPU_start = 1'b1;
    #3;
    reset_n = 1'b1;
    tick();
    n_checks++; if (bus1.Ext_MemWrite !== 1'b1) begin n_fail++; $display("FAIL rel_start_wr got %b exp 1", bus1.Ext_MemWrite); end
    n_checks++; if (bus1.Ext_DataAdr !== BASE) begin n_fail++; $display("FAIL rel_start_adr got %h exp %h", bus1.Ext_DataAdr, BASE); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rel_start_busy got %b exp 1", busy); end
    reset_n   = 1'b0;
    CPU_start = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  // Four words with three idle cycles each on the second instance.
  task automatic test_cfg2();
    int          period, total, widx;
    logic        exp_wr;
    logic [31:0] exp_adr, exp_dat;
    logic [127:0] w;
    period = 1 + GAP2;
    total  = NI2 * period;
    w = {$urandom, $urandom, $urandom, $urandom};
    init_data2 = w;
    CPU_start2 = 1'b1;
    tick();
    CPU_start2 = 1'b0;
    for (int off = 0; off <= total; off++) begin
      exp_wr  = (off < total) && ((off % period) == 0);
      widx    = off / period;
      exp_adr = 32'h0;
      exp_dat = 32'h0;
      if (exp_wr) begin
        exp_adr = BASE + 32'(4 * widx);
        exp_dat = w[widx*32 +: 32];
      end
      n_checks++; if (bus2.Ext_MemWrite !== exp_wr) begin n_fail++; $display("FAIL cfg2_wr off=%0d got %b exp %b", off, bus2.Ext_MemWrite, exp_wr); end
      n_checks++; if (bus2.Ext_DataAdr !== exp_adr) begin n_fail++; $display("FAIL cfg2_adr off=%0d got %h exp %h", off, bus2.Ext_DataAdr, exp_adr); end
      n_checks++; if (bus2.Ext_WriteData !== exp_dat) begin n_fail++; $display("FAIL cfg2_dat off=%0d got %h exp %h", off, bus2.Ext_WriteData, exp_dat); end
      n_checks++; if (bus2.cpu_reset !== (off < total)) begin n_fail++; $display("FAIL cfg2_cpu_reset off=%0d got %b exp %b", off, bus2.cpu_reset, (off < total)); end
      if (off < total) tick();
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    CPU_start      = 1'b0;
    CPU_start2     = 1'b0;
    init_data      = '0;
    init_data2     = '0;
    bus1.Mem_write = 1'b0;
    bus1.WriteData = '0;
    bus1.DataAdr   = '0;
    bus2.Mem_write = 1'b0;
    bus2.WriteData = '0;
    bus2.DataAdr   = '0;
    tick();
    tick();

    test_reset();
    test_boot({32'h0000_00A5, 32'h0000_005A}, 1'b0);
    test_capture(8'b0100_1101, 1'b0);
    for (int it = 0; it < 4; it++) begin
      test_boot({$urandom, $urandom}, 1'b1);
      test_capture(8'($urandom), 1'b1);
    end
    test_hold_start();
    test_capture(8'($urandom), 1'b1);
    test_reset_midseq();
    test_reset_start_high();
    test_cfg2();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
